// File: rtl/serial_crc_pkg.sv
// Shared definitions for the serial CRC-CCITT checker: default CRC constants,
// the frame FSM state type and the single-bit CRC update helper.
package serial_crc_pkg;

  localparam logic [15:0] CRC_POLY_DEF = 16'h1021;
  localparam logic [15:0] CRC_INIT_DEF = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    FCS     = 2'd2
  } state_e;

  // One MSB-first CRC step: no reflection, no final XOR.
  function automatic logic [15:0] crc_ccitt_step(
    input logic [15:0] crc,
    input logic        din,
    input logic [15:0] poly = CRC_POLY_DEF
  );
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
  endfunction

endpackage

// File: rtl/crc_ccitt_lfsr.sv
// 16-bit CRC-CCITT LFSR with preset and enable. Preset together with enable
// restarts the register and folds in the current bit in the same cycle, so the
// first bit of a frame needs no dead cycle.
module crc_ccitt_lfsr
  import serial_crc_pkg::*;
#(
  parameter logic [15:0] INIT = CRC_INIT_DEF,
  parameter logic [15:0] POLY = CRC_POLY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        preset,
  input  logic        enable,
  input  logic        din,
  output logic [15:0] crc
);

  // CRC register: preset, preset-and-step, step, or hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc <= INIT;
    end else if (preset && enable) begin
      crc <= crc_ccitt_step(INIT, din, POLY);
    end else if (preset) begin
      crc <= INIT;
    end else if (enable) begin
      crc <= crc_ccitt_step(crc, din, POLY);
    end else begin
      crc <= crc;
    end
  end

endmodule

// File: rtl/serial_crc_ccitt_checker.sv
// Receive-side serial CRC-CCITT checker. Recomputes the CRC over an MSB-first
// payload, captures the trailing 16-bit FCS and emits a one-cycle verdict.
// Optional build macro CRC_CHECKER_ERRCNT_EN adds a saturating err_count output.
module serial_crc_ccitt_checker
  import serial_crc_pkg::*;
#(
  parameter int          LEN_W    = 16,
  parameter logic [15:0] CRC_INIT = CRC_INIT_DEF,
  parameter logic [15:0] CRC_POLY = CRC_POLY_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             sof,
  input  logic [LEN_W-1:0] frame_len,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic [15:0]      calc_crc,
  output logic [15:0]      rx_crc
`ifdef CRC_CHECKER_ERRCNT_EN
  ,
  output logic [15:0]      err_count
`endif
);

  state_e           state_r;
  state_e           state_s;
  logic [LEN_W-1:0] pay_cnt_r;
  logic [3:0]       fcs_cnt_r;
  logic [15:0]      rx_sr_r;
  logic [15:0]      crc_s;
  logic [15:0]      rx_word_s;
  logic             sof_acc_s;
  logic             len_zero_s;
  logic             len_one_s;
  logic             last_pay_s;
  logic             last_fcs_s;
  logic             lfsr_preset_s;
  logic             lfsr_en_s;
  logic             pay_dec_s;
  logic             fcs_shift_s;
  logic             verdict_s;
  logic             mismatch_s;

  // sof while busy is not special: any accepted sof restarts the frame.
  assign sof_acc_s  = bit_valid & sof;
  assign len_zero_s = (frame_len == {LEN_W{1'b0}});
  assign len_one_s  = (frame_len == LEN_W'(1'b1));
  assign last_pay_s = (pay_cnt_r == LEN_W'(1'b1));
  assign last_fcs_s = (fcs_cnt_r == 4'd15);
  assign rx_word_s  = {rx_sr_r[14:0], bit_in};
  assign mismatch_s = (crc_s != rx_word_s);

  crc_ccitt_lfsr #(
    .INIT (CRC_INIT),
    .POLY (CRC_POLY)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .preset (lfsr_preset_s),
    .enable (lfsr_en_s),
    .din    (bit_in),
    .crc    (crc_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state: sof always wins, otherwise advance on valid bits only.
  always_comb begin
    state_s = state_r;
    if (sof_acc_s) begin
      state_s = (len_zero_s || len_one_s) ? FCS : PAYLOAD;
    end else if (bit_valid) begin
      case (state_r)
        IDLE:    state_s = IDLE;
        PAYLOAD: state_s = last_pay_s ? FCS : PAYLOAD;
        FCS:     state_s = last_fcs_s ? IDLE : FCS;
        default: state_s = IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // FSM outputs: datapath strobes for the LFSR, counters and verdict.
  always_comb begin
    lfsr_preset_s = 1'b0;
    lfsr_en_s     = 1'b0;
    pay_dec_s     = 1'b0;
    fcs_shift_s   = 1'b0;
    verdict_s     = 1'b0;
    if (sof_acc_s) begin
      // An empty frame's first bit is FCS, so the CRC stays at its preset.
      lfsr_preset_s = 1'b1;
      lfsr_en_s     = ~len_zero_s;
    end else if (bit_valid) begin
      case (state_r)
        IDLE: begin
          lfsr_en_s = 1'b0;
        end
        PAYLOAD: begin
          lfsr_en_s = 1'b1;
          pay_dec_s = 1'b1;
        end
        FCS: begin
          fcs_shift_s = 1'b1;
          verdict_s   = last_fcs_s;
        end
        default: begin
          lfsr_en_s = 1'b0;
        end
      endcase
    end else begin
      lfsr_en_s = 1'b0;
    end
  end

  // Payload countdown, FCS bit counter and FCS shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pay_cnt_r <= {LEN_W{1'b0}};
      fcs_cnt_r <= 4'd0;
      rx_sr_r   <= 16'h0000;
    end else if (sof_acc_s) begin
      pay_cnt_r <= len_zero_s ? {LEN_W{1'b0}} : (frame_len - LEN_W'(1'b1));
      fcs_cnt_r <= len_zero_s ? 4'd1 : 4'd0;
      rx_sr_r   <= {15'h0000, bit_in};
    end else begin
      if (pay_dec_s) begin
        pay_cnt_r <= pay_cnt_r - LEN_W'(1'b1);
      end
      if (fcs_shift_s) begin
        fcs_cnt_r <= fcs_cnt_r + 4'd1;
        rx_sr_r   <= rx_word_s;
      end
    end
  end

  // Verdict registers: done/ok/err pulse for one cycle, CRC words held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done     <= 1'b0;
      crc_ok   <= 1'b0;
      crc_err  <= 1'b0;
      calc_crc <= 16'h0000;
      rx_crc   <= 16'h0000;
    end else if (verdict_s) begin
      done     <= 1'b1;
      crc_ok   <= ~mismatch_s;
      crc_err  <= mismatch_s;
      calc_crc <= crc_s;
      rx_crc   <= rx_word_s;
    end else begin
      done    <= 1'b0;
      crc_ok  <= 1'b0;
      crc_err <= 1'b0;
    end
  end

  // Busy flag registered from the next state so it tracks state_r exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_s != IDLE);
    end
  end

`ifdef CRC_CHECKER_ERRCNT_EN
  // Saturating count of failed frames, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= 16'h0000;
    end else if (verdict_s && mismatch_s && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end else begin
      err_count <= err_count;
    end
  end
`endif

endmodule

// File: tb/tb_serial_crc_ccitt_checker.sv
// Self-checking bench for serial_crc_ccitt_checker: directed frames with a
// scoreboard of expected verdicts popped whenever done is observed.
module tb_serial_crc_ccitt_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        bit_valid;
  logic        bit_in;
  logic        sof;
  logic [15:0] frame_len;
  logic        busy;
  logic        done;
  logic        crc_ok;
  logic        crc_err;
  logic [15:0] calc_crc;
  logic [15:0] rx_crc;
`ifdef CRC_CHECKER_ERRCNT_EN
  logic [15:0] err_count;
`endif

  typedef struct packed {
    logic        ok;
    logic [15:0] calc;
    logic [15:0] rx;
  } exp_t;

  exp_t exp_q[$];
  logic pay_q[$];
  int   tests     = 0;
  int   fails     = 0;
  int   done_seen = 0;

  serial_crc_ccitt_checker dut (
    .clk       (clk),
    .reset     (reset),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .sof       (sof),
    .frame_len (frame_len),
    .busy      (busy),
    .done      (done),
    .crc_ok    (crc_ok),
    .crc_err   (crc_err),
    .calc_crc  (calc_crc),
    .rx_crc    (rx_crc)
`ifdef CRC_CHECKER_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge; score any verdict.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (done === 1'b1) begin
      done_seen++;
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_done: observed done=1 expected no pending frame");
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check16("crc_ok", {15'h0000, crc_ok}, {15'h0000, e.ok});
        check16("crc_err", {15'h0000, crc_err}, {15'h0000, ~e.ok});
        check16("calc_crc", calc_crc, e.calc);
        check16("rx_crc", rx_crc, e.rx);
      end
    end
  endtask

  task automatic drive(input logic v, input logic b, input logic s, input logic [15:0] len);
    bit_valid = v;
    bit_in    = b;
    sof       = s;
    frame_len = len;
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic load_ascii();
    logic [7:0] c;
    pay_q.delete();
    for (int k = 0; k < 9; k++) begin
      c = 8'h31 + 8'(k);
      for (int j = 7; j >= 0; j--) pay_q.push_back(c[j]);
    end
  endtask

  task automatic load_random(input int n);
    pay_q.delete();
    for (int k = 0; k < n; k++) pay_q.push_back(1'($urandom));
  endtask

  // Bit-serial reference CRC over pay_q, straight from the polynomial.
  function automatic logic [15:0] model_crc();
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (pay_q[k]) begin
      fb = c[15] ^ pay_q[k];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // Send pay_q then fcs; stop_after>=0 truncates the frame (no verdict expected).
  task automatic send_frame(input logic [15:0] fcs, input int max_gap,
                            input logic [15:0] exp_calc, input int stop_after);
    exp_t       e;
    int         len;
    logic       b;
    logic [15:0] len16;
    len   = pay_q.size();
    len16 = 16'(len);
    if (stop_after < 0) begin
      e.ok   = (exp_calc == fcs);
      e.calc = exp_calc;
      e.rx   = fcs;
      exp_q.push_back(e);
    end
    for (int i = 0; i < len + 16; i++) begin
      if (stop_after >= 0 && i >= stop_after) break;
      if (max_gap > 0) begin
        repeat ($urandom_range(max_gap, 0)) drive(1'b0, 1'($urandom), 1'($urandom), 16'hFFFF);
      end
      b = (i < len) ? pay_q[i] : fcs[15 - (i - len)];
      drive(1'b1, b, (i == 0), len16);
    end
  endtask

  initial begin
    int          d0;
    logic [15:0] m;
    reset     = 1'b1;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    sof       = 1'b0;
    frame_len = 16'h0000;
    idle(3);
    check16("rst_busy", {15'h0000, busy}, 16'h0000);
    check16("rst_done", {15'h0000, done}, 16'h0000);
    check16("rst_ok", {15'h0000, crc_ok}, 16'h0000);
    check16("rst_err", {15'h0000, crc_err}, 16'h0000);
    check16("rst_calc", calc_crc, 16'h0000);
    check16("rst_rx", rx_crc, 16'h0000);
    reset = 1'b0;
    idle(2);

    // Check string, good then bad FCS.
    load_ascii();
    d0 = done_seen;
    send_frame(16'h29B1, 0, 16'h29B1, -1);
    idle(3);
    check16("s1_done_count", 16'(done_seen - d0), 16'd1);
    send_frame(16'h29B0, 0, 16'h29B1, -1);
    idle(3);

    // Empty frames: FCS alone, compared against the preset value.
    pay_q.delete();
    send_frame(16'hFFFF, 0, 16'hFFFF, -1);
    send_frame(16'h0000, 0, 16'hFFFF, -1);
    idle(3);

    // Random stalls with sof toggling during gaps.
    load_ascii();
    d0 = done_seen;
    send_frame(16'h29B1, 5, 16'h29B1, -1);
    idle(3);
    check16("s4_done_count", 16'(done_seen - d0), 16'd1);

    // Back-to-back frames with no dead cycle.
    d0 = done_seen;
    send_frame(16'h29B1, 0, 16'h29B1, -1);
    send_frame(16'h29B1, 0, 16'h29B1, -1);
    idle(3);
    check16("b2b_done_count", 16'(done_seen - d0), 16'd2);

    // Abort after 20 bits by a fresh sof.
    d0 = done_seen;
    send_frame(16'h29B1, 0, 16'h29B1, 20);
    check16("abort_busy", {15'h0000, busy}, 16'h0001);
    send_frame(16'h29B1, 0, 16'h29B1, -1);
    idle(3);
    check16("abort_done_count", 16'(done_seen - d0), 16'd1);

    // Single-bit payload and a random-length payload.
    load_random(1);
    m = model_crc();
    send_frame(m, 0, m, -1);
    load_random(37);
    m = model_crc();
    send_frame(m, 2, m, -1);
    idle(3);

    // Reset in the middle of the payload.
    load_ascii();
    d0 = done_seen;
    send_frame(16'h29B1, 0, 16'h29B1, 40);
    reset     = 1'b1;
    bit_valid = 1'b0;
    #2;
    check16("mid_busy", {15'h0000, busy}, 16'h0000);
    check16("mid_done", {15'h0000, done}, 16'h0000);
    check16("mid_ok", {15'h0000, crc_ok}, 16'h0000);
    check16("mid_err", {15'h0000, crc_err}, 16'h0000);
    check16("mid_calc", calc_crc, 16'h0000);
    check16("mid_rx", rx_crc, 16'h0000);
`ifdef CRC_CHECKER_ERRCNT_EN
    check16("mid_err_count", err_count, 16'h0000);
`endif
    idle(2);
    reset = 1'b0;
    idle(2);
    send_frame(16'h29B1, 0, 16'h29B1, -1);
    idle(3);
    check16("post_rst_done_count", 16'(done_seen - d0), 16'd1);

    // Three bad frames.
    send_frame(16'h1234, 0, 16'h29B1, -1);
    send_frame(16'hA9B1, 1, 16'h29B1, -1);
    load_random(23);
    m = model_crc();
    send_frame(m ^ 16'h0001, 0, m, -1);
    idle(4);
`ifdef CRC_CHECKER_ERRCNT_EN
    check16("err_count", err_count, 16'd3);
`endif

    check16("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
